// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: level encodings, vector defaults,
// FSM states and the one-hot level to vector-index helper.
package interrupt_sequencer_pkg;

    localparam int LVL_W = 3;

    localparam logic [LVL_W-1:0] LVL_NONE = 3'b000;
    localparam logic [LVL_W-1:0] LVL_0    = 3'b001;
    localparam logic [LVL_W-1:0] LVL_1    = 3'b010;
    localparam logic [LVL_W-1:0] LVL_2    = 3'b100;

    localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEF_VECTOR_STRIDE = 32'h0000_0010;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } seq_state_e;

    // Non-one-hot codes map to index 0; the controller never produces them.
    function automatic logic [1:0] lvl_to_idx(input logic [LVL_W-1:0] lvl);
        logic [1:0] idx;
        case (lvl)
            LVL_0:   idx = 2'd0;
            LVL_1:   idx = 2'd1;
            LVL_2:   idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_epc_stack.sv
// LIFO of saved return addresses; one entry per nested interrupt level.
// Push into a full stack and pop from an empty one are ignored.
module epc_stack
    import interrupt_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 3,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] din,
    output logic [PC_WIDTH-1:0] top,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);

    logic [PC_WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]       count_r;
    logic                full_s;
    logic                empty_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});

    // Storage and occupancy; push and pop are mutually exclusive at the caller.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {PC_WIDTH{1'b0}};
            end
        end else if (push && !full_s) begin
            mem_r[count_r] <= din;
            count_r        <= count_r + CW'(1);
        end else if (pop && !empty_s) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Top-of-stack read; reads as zero when empty.
    always_comb begin
        top = {PC_WIDTH{1'b0}};
        if (!empty_s) begin
            top = mem_r[count_r - CW'(1)];
        end else begin
            top = {PC_WIDTH{1'b0}};
        end
    end

    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/interrupt_sequencer.sv
// CPU-side interrupt responder: saves the return PC on handler entry, redirects fetch to
// the level vector, and on eret restores the PC and tells the controller to retire a level.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH      = 32,
    parameter int                  DEPTH         = 3,
    parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = PC_WIDTH'(DEF_VECTOR_BASE),
    parameter logic [PC_WIDTH-1:0] VECTOR_STRIDE = PC_WIDTH'(DEF_VECTOR_STRIDE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [LVL_W-1:0]    interruptOut,
    input  logic                interrupted,
    input  logic [PC_WIDTH-1:0] pcCurrent,
    input  logic                stall,
    input  logic                eret,
    output logic                pcRedirect,
    output logic [PC_WIDTH-1:0] pcTarget,
    output logic                interruptEnd,
    output logic                inHandler,
    output logic [1:0]          nestLevel,
    output logic                stackOverflow
);

    localparam int CW = $clog2(DEPTH + 1);

    seq_state_e          state_r;
    seq_state_e          state_next_s;
    logic [LVL_W-1:0]    pend_lvl_r;
    logic [LVL_W-1:0]    pend_lvl_next_s;

    logic                irq_valid_s;
    logic                eret_take_s;
    logic                push_s;
    logic                ovf_set_s;
    logic [PC_WIDTH-1:0] vector_s;

    logic [PC_WIDTH-1:0] top_s;
    logic [CW-1:0]       count_s;
    logic                full_s;
    logic                empty_s;

    logic                pc_redirect_r;
    logic [PC_WIDTH-1:0] pc_target_r;
    logic                interrupt_end_r;
    logic                in_handler_r;
    logic                overflow_r;

    epc_stack #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (DEPTH),
        .CW       (CW)
    ) u_epc_stack (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (eret_take_s),
        .din   (pcCurrent),
        .top   (top_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign irq_valid_s = interrupted && (interruptOut != LVL_NONE);
    assign eret_take_s = eret && !empty_s;
    assign vector_s    = VECTOR_BASE
                       + ({{(PC_WIDTH-2){1'b0}}, lvl_to_idx(pend_lvl_r)} * VECTOR_STRIDE);

    // State and pending-level registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            pend_lvl_r <= LVL_NONE;
        end else begin
            state_r    <= state_next_s;
            pend_lvl_r <= pend_lvl_next_s;
        end
    end

    // Entry sequencing: a fresh pulse re-arms the pending level, a retiring eret defers entry.
    always_comb begin
        state_next_s    = state_r;
        pend_lvl_next_s = pend_lvl_r;
        push_s          = 1'b0;
        ovf_set_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (irq_valid_s) begin
                    state_next_s    = S_PEND;
                    pend_lvl_next_s = interruptOut;
                end else begin
                    state_next_s    = S_IDLE;
                end
            end
            S_PEND: begin
                if (irq_valid_s) begin
                    state_next_s    = S_PEND;
                    pend_lvl_next_s = interruptOut;
                end else if (!stall && !eret_take_s) begin
                    state_next_s    = S_IDLE;
                    pend_lvl_next_s = LVL_NONE;
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        push_s    = 1'b1;
                    end
                end else begin
                    state_next_s    = S_PEND;
                end
            end
            default: begin
                state_next_s    = S_IDLE;
                pend_lvl_next_s = LVL_NONE;
            end
        endcase
    end

    // Registered redirect, retire pulse and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_redirect_r   <= 1'b0;
            pc_target_r     <= {PC_WIDTH{1'b0}};
            interrupt_end_r <= 1'b0;
            in_handler_r    <= 1'b0;
            overflow_r      <= 1'b0;
        end else begin
            pc_redirect_r   <= eret_take_s | push_s;
            interrupt_end_r <= eret_take_s;
            overflow_r      <= overflow_r | ovf_set_s;
            if (eret_take_s) begin
                pc_target_r <= top_s;
            end else if (push_s) begin
                pc_target_r <= vector_s;
            end else begin
                pc_target_r <= {PC_WIDTH{1'b0}};
            end
            if (push_s) begin
                in_handler_r <= 1'b1;
            end else if (eret_take_s) begin
                in_handler_r <= (count_s != CW'(1));
            end else begin
                in_handler_r <= in_handler_r;
            end
        end
    end

    assign pcRedirect    = pc_redirect_r;
    assign pcTarget      = pc_target_r;
    assign interruptEnd  = interrupt_end_r;
    assign inHandler     = in_handler_r;
    assign nestLevel     = 2'(count_s);
    assign stackOverflow = overflow_r;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios against fixed addresses plus a random
// run checked against a queue-based model of the entry/return rules.
module tb_interrupt_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  interruptOut;
    logic        interrupted;
    logic [31:0] pcCurrent;
    logic        stall;
    logic        eret;
    logic        pcRedirect;
    logic [31:0] pcTarget;
    logic        interruptEnd;
    logic        inHandler;
    logic [1:0]  nestLevel;
    logic        stackOverflow;

    int checks = 0;
    int errors = 0;

    interrupt_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .interruptOut  (interruptOut),
        .interrupted   (interrupted),
        .pcCurrent     (pcCurrent),
        .stall         (stall),
        .eret          (eret),
        .pcRedirect    (pcRedirect),
        .pcTarget      (pcTarget),
        .interruptEnd  (interruptEnd),
        .inHandler     (inHandler),
        .nestLevel     (nestLevel),
        .stackOverflow (stackOverflow)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        reset = 1'b0; interrupted = 1'b0; interruptOut = 3'b000;
        pcCurrent = 32'h0; stall = 1'b0; eret = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Drive one cycle of inputs, advance past the edge, then drop the pulses.
    task automatic step(input logic irq, input logic [2:0] lvl, input logic [31:0] pc,
                        input logic stl, input logic er);
        interrupted = irq; interruptOut = lvl; pcCurrent = pc; stall = stl; eret = er;
        @(posedge clock); #1;
        interrupted = 1'b0; eret = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; interrupted = 1'b0; interruptOut = 3'b000;
        pcCurrent = 32'h0; stall = 1'b0; eret = 1'b0;
        #3;
        checks++;
        if ({pcRedirect, pcTarget, interruptEnd, inHandler, nestLevel, stackOverflow} !== 37'd0) begin
            errors++; $display("FAIL reset_state: got %b %h %b %b %0d %b expected all zero",
                               pcRedirect, pcTarget, interruptEnd, inHandler, nestLevel, stackOverflow);
        end
        apply_reset();
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({pcRedirect, nestLevel, stackOverflow} !== 4'd0) begin
            errors++; $display("FAIL reset_release: got red=%b nest=%0d ovf=%b expected 0 0 0",
                               pcRedirect, nestLevel, stackOverflow);
        end
    endtask

    task automatic test_single();
        apply_reset();
        step(1'b1, 3'b001, 32'h40, 1'b0, 1'b0);
        checks++;
        if (pcRedirect !== 1'b0) begin
            errors++; $display("FAIL single_capture: got red=%b expected 0", pcRedirect);
        end
        step(1'b0, 3'b001, 32'h40, 1'b0, 1'b0);
        checks++;
        if ({pcRedirect, pcTarget, nestLevel, inHandler} !== {1'b1, 32'h100, 2'd1, 1'b1}) begin
            errors++; $display("FAIL single_entry: got red=%b tgt=%h nest=%0d ih=%b expected 1 00000100 1 1",
                               pcRedirect, pcTarget, nestLevel, inHandler);
        end
        step(1'b0, 3'b001, 32'h100, 1'b0, 1'b0);
        checks++;
        if ({pcRedirect, interruptEnd} !== 2'b00) begin
            errors++; $display("FAIL single_one_pulse: got red=%b end=%b expected 0 0", pcRedirect, interruptEnd);
        end
        step(1'b0, 3'b001, 32'h108, 1'b0, 1'b1);
        checks++;
        if ({pcRedirect, pcTarget, interruptEnd, nestLevel, inHandler} !== {1'b1, 32'h40, 1'b1, 2'd0, 1'b0}) begin
            errors++; $display("FAIL single_eret: got red=%b tgt=%h end=%b nest=%0d ih=%b expected 1 00000040 1 0 0",
                               pcRedirect, pcTarget, interruptEnd, nestLevel, inHandler);
        end
        step(1'b0, 3'b000, 32'h40, 1'b0, 1'b0);
        checks++;
        if ({pcRedirect, interruptEnd} !== 2'b00) begin
            errors++; $display("FAIL single_end_pulse: got red=%b end=%b expected 0 0", pcRedirect, interruptEnd);
        end
    endtask

    task automatic test_nesting();
        logic [31:0] exp_tgt [4] = '{32'h100, 32'h120, 32'h104, 32'h40};
        logic [1:0]  exp_nest [4] = '{2'd1, 2'd2, 2'd1, 2'd0};
        apply_reset();
        step(1'b1, 3'b001, 32'h40, 1'b0, 1'b0);
        step(1'b0, 3'b001, 32'h40, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                step(1'b1, 3'b100, 32'h104, 1'b0, 1'b0);
                step(1'b0, 3'b100, 32'h104, 1'b0, 1'b0);
            end else if (k >= 2) begin
                step(1'b0, 3'b000, 32'h200, 1'b0, 1'b0);
                step(1'b0, 3'b000, 32'h204, 1'b0, 1'b1);
            end
            checks++;
            if ({pcRedirect, pcTarget, nestLevel, interruptEnd} !== {1'b1, exp_tgt[k], exp_nest[k], (k >= 2)}) begin
                errors++; $display("FAIL nesting_%0d: got red=%b tgt=%h nest=%0d end=%b expected 1 %h %0d %b",
                                   k, pcRedirect, pcTarget, nestLevel, interruptEnd, exp_tgt[k], exp_nest[k], (k >= 2));
            end
        end
    endtask

    task automatic test_stall();
        int seen = 0;
        apply_reset();
        step(1'b1, 3'b010, 32'h200, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) step(1'b1, 3'b001, 32'h200 + 32'(k * 4), 1'b1, 1'b0);
            else        step(1'b0, 3'b000, 32'h200 + 32'(k * 4), 1'b1, 1'b0);
            if (pcRedirect !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL stall_hold: got %0d redirects expected 0", seen);
        end
        step(1'b0, 3'b000, 32'h300, 1'b0, 1'b0);
        checks++;
        if ({pcRedirect, pcTarget, nestLevel} !== {1'b1, 32'h100, 2'd1}) begin
            errors++; $display("FAIL stall_release: got red=%b tgt=%h nest=%0d expected 1 00000100 1",
                               pcRedirect, pcTarget, nestLevel);
        end
        step(1'b0, 3'b000, 32'h100, 1'b1, 1'b1);
        checks++;
        if ({pcRedirect, pcTarget} !== {1'b1, 32'h300}) begin
            errors++; $display("FAIL stall_epc: got red=%b tgt=%h expected 1 00000300", pcRedirect, pcTarget);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'b001, 32'h1000 + 32'(k * 16), 1'b0, 1'b0);
            step(1'b0, 3'b000, 32'h1000 + 32'(k * 16), 1'b0, 1'b0);
            checks++;
            if (k < 3) begin
                if ({pcRedirect, nestLevel, stackOverflow} !== {1'b1, 2'(k + 1), 1'b0}) begin
                    errors++; $display("FAIL overflow_fill_%0d: got red=%b nest=%0d ovf=%b expected 1 %0d 0",
                                       k, pcRedirect, nestLevel, stackOverflow, k + 1);
                end
            end else begin
                if ({pcRedirect, nestLevel, stackOverflow} !== {1'b0, 2'd3, 1'b1}) begin
                    errors++; $display("FAIL overflow_full: got red=%b nest=%0d ovf=%b expected 0 3 1",
                                       pcRedirect, nestLevel, stackOverflow);
                end
            end
        end
        step(1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
        checks++;
        if ({pcTarget, stackOverflow} !== {32'h1020, 1'b1}) begin
            errors++; $display("FAIL overflow_sticky: got tgt=%h ovf=%b expected 00001020 1", pcTarget, stackOverflow);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(1'b1, 3'b001, 32'h40, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h40, 1'b0, 1'b0);
        step(1'b1, 3'b010, 32'h104, 1'b0, 1'b1);
        checks++;
        if ({pcRedirect, pcTarget, interruptEnd, nestLevel} !== {1'b1, 32'h40, 1'b1, 2'd0}) begin
            errors++; $display("FAIL b2b_eret_first: got red=%b tgt=%h end=%b nest=%0d expected 1 00000040 1 0",
                               pcRedirect, pcTarget, interruptEnd, nestLevel);
        end
        step(1'b0, 3'b000, 32'h40, 1'b0, 1'b0);
        checks++;
        if ({pcRedirect, pcTarget, interruptEnd, nestLevel} !== {1'b1, 32'h40 - 32'h40 + 32'h110, 1'b0, 2'd1}) begin
            errors++; $display("FAIL b2b_entry_next: got red=%b tgt=%h end=%b nest=%0d expected 1 00000110 0 1",
                               pcRedirect, pcTarget, interruptEnd, nestLevel);
        end
        step(1'b0, 3'b000, 32'h114, 1'b0, 1'b1);
        checks++;
        if ({pcTarget, nestLevel} !== {32'h40, 2'd0}) begin
            errors++; $display("FAIL b2b_return: got tgt=%h nest=%0d expected 00000040 0", pcTarget, nestLevel);
        end
        step(1'b0, 3'b000, 32'h40, 1'b0, 1'b1);
        checks++;
        if ({pcRedirect, interruptEnd, nestLevel} !== 4'd0) begin
            errors++; $display("FAIL eret_empty: got red=%b end=%b nest=%0d expected 0 0 0",
                               pcRedirect, interruptEnd, nestLevel);
        end
    endtask

    task automatic test_async_reset();
        int seen = 0;
        apply_reset();
        step(1'b1, 3'b001, 32'h40, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h40, 1'b0, 1'b0);
        step(1'b1, 3'b010, 32'h104, 1'b0, 1'b0);
        step(1'b0, 3'b000, 32'h104, 1'b0, 1'b0);
        step(1'b1, 3'b100, 32'h114, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({pcRedirect, pcTarget, interruptEnd, inHandler, nestLevel, stackOverflow} !== 37'd0) begin
            errors++; $display("FAIL async_reset: got %b %h %b %b %0d %b expected all zero",
                               pcRedirect, pcTarget, interruptEnd, inHandler, nestLevel, stackOverflow);
        end
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'b000, 32'h500, 1'b0, 1'b0);
            if (pcRedirect !== 1'b0 || nestLevel !== 2'd0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL async_reset_release: got %0d bad cycles expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_stack [$];
        bit          m_pend = 1'b0;
        logic [2:0]  m_lvl  = 3'b000;
        bit          m_ovf  = 1'b0;
        bit          m_red, m_end, eret_ok;
        logic [31:0] m_tgt;
        logic [2:0]  lvl;
        logic        irq, stl, er;
        logic [31:0] pc;
        int          idx;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            stl = ($urandom_range(0, 2) == 0);
            er  = (m_stack.size() > 0) && ($urandom_range(0, 5) == 0);
            irq = (!m_pend || stl) && ($urandom_range(0, 3) == 0);
            lvl = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) lvl = 3'b000;
            pc  = $urandom & 32'hFFFF_FFFC;
            m_red = 1'b0; m_end = 1'b0; m_tgt = 32'h0; eret_ok = 1'b0;
            if (er && m_stack.size() > 0) begin
                m_tgt = m_stack.pop_back(); m_red = 1'b1; m_end = 1'b1; eret_ok = 1'b1;
            end
            if (irq && lvl != 3'b000) begin
                m_pend = 1'b1; m_lvl = lvl;
            end else if (m_pend && !stl && !eret_ok) begin
                m_pend = 1'b0;
                if (m_stack.size() >= 3) begin
                    m_ovf = 1'b1;
                end else begin
                    idx = 0;
                    for (int i = 0; i < 3; i++) if (m_lvl[i]) idx = i;
                    m_stack.push_back(pc);
                    m_red = 1'b1;
                    m_tgt = 32'h100 + 32'(idx) * 32'h10;
                end
            end
            step(irq, lvl, pc, stl, er);
            checks++;
            if ({pcRedirect, interruptEnd, nestLevel, inHandler, stackOverflow} !==
                {m_red, m_end, 2'(m_stack.size()), (m_stack.size() != 0), m_ovf}
                || (m_red && pcTarget !== m_tgt)) begin
                errors++; $display("FAIL random_c%0d: got red=%b end=%b nest=%0d ih=%b ovf=%b tgt=%h expected %b %b %0d %b %b %h",
                                   c, pcRedirect, interruptEnd, nestLevel, inHandler, stackOverflow, pcTarget,
                                   m_red, m_end, m_stack.size(), (m_stack.size() != 0), m_ovf, m_tgt);
            end
            if (m_ovf && $urandom_range(0, 3) == 0) begin
                apply_reset();
                m_stack.delete(); m_pend = 1'b0; m_ovf = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_nesting();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
